// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing controller: steps one shared ALU and memory port through
// FETCH..WRITEBACK per instruction, with a bounded memory wait and retire counter.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        halted,
    output logic [1:0]  err,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LS, MEM_RD, MEM_WR,
        WB_ALU, WB_MEM, BRANCH, JALR, HALT
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ILL  = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;

    state_e      state_q, state_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  wait_q, wait_d;
    logic        imm_q, imm_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            err_q     <= ERR_NONE;
            wait_q    <= 8'd0;
            imm_q     <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            imm_q     <= imm_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        wait_d    = wait_q;
        imm_d     = imm_q;
        retire    = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        alu_src   = 1'b0;
        alu_op    = 2'b00;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halted    = 1'b0;
        err       = ERR_NONE;

        unique case (state_q)
            FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                unique case (opcode)
                    OP_R:            state_d = EXEC_R;
                    OP_I:            state_d = EXEC_I;
                    OP_LOAD, OP_STOR: state_d = EXEC_LS;
                    OP_BEQ:          state_d = BRANCH;
                    OP_JALR:         state_d = JALR;
                    default: begin
                        state_d = HALT;
                        err_d   = ERR_ILL;
                    end
                endcase
            end
            EXEC_R: begin
                alu_op  = 2'b10;
                imm_d   = 1'b0;
                state_d = WB_ALU;
            end
            EXEC_I: begin
                alu_src = 1'b1;
                alu_op  = 2'b11;
                imm_d   = 1'b1;
                state_d = WB_ALU;
            end
            EXEC_LS: begin
                alu_src = 1'b1;
                wait_d  = 8'd0;
                state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD, MEM_WR: begin
                alu_src   = 1'b1;
                mem_read  = (state_q == MEM_RD);
                mem_write = (state_q == MEM_WR);
                // Ready wins over timeout when both land in the same cycle.
                if (mem_ready) begin
                    state_d = (state_q == MEM_RD) ? WB_MEM : FETCH;
                    retire  = (state_q == MEM_WR);
                end else if (wait_q == TIMEOUT) begin
                    state_d = HALT;
                    err_d   = ERR_TO;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WB_ALU: begin
                reg_write = 1'b1;
                alu_src   = imm_q;
                alu_op    = imm_q ? 2'b11 : 2'b10;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_op   = 2'b01;
                pc_src   = 2'b01;
                pc_write = zero;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            JALR: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                pc_write  = 1'b1;
                pc_src    = 2'b10;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            HALT: begin
                halted = 1'b1;
                err    = err_q;
            end
            default: state_d = FETCH;
        endcase

        instret_d = retire ? instret_q + 32'd1 : instret_q;

        // Outputs are forced low for as long as reset is held, not just after the edge.
        if (reset) begin
            pc_write  = 1'b0;
            pc_src    = 2'b00;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            wb_sel    = 2'b00;
            alu_src   = 1'b0;
            alu_op    = 2'b00;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            halted    = 1'b0;
            err       = ERR_NONE;
        end
    end

    assign instret = instret_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencing controller for the RISC-V core: replaces the combinational main controller so one ALU and one data-memory port are reused across the FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps of each instruction. It consumes the opcode from the instruction register and the ALU zero flag, and drives every datapath strobe and mux select. It waits on a data-memory ready handshake with a bounded timeout, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 15: max cycles spent waiting for mem_ready in a memory state before halting (1..255).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH, counters 0, and all outputs 0 while asserted.
- opcode  in  7  Instruct[6:0] from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag; sampled in BRANCH.
- mem_ready  in  1  data memory has completed the current read or write this cycle.
- pc_write  out  1  PC register load enable.
- pc_src  out  2  PC input select: 00 = PC+4, 01 = branch target (old_pc + imm<<1), 10 = ALUOut[31:0].
- ir_write  out  1  instruction register and old_pc register load enable.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  writeback select: 00 = ALUOut, 01 = DataOutput, 10 = old_pc+4.
- alu_src  out  1  ALU operand B select: 0 = RD2, 1 = immediate.
- alu_op  out  2  to ALUControl: 00 add, 01 sub (branch compare), 10 R-type funct decode, 11 I-type funct decode (ignores Instruct[30] except for shifts).
- mem_read  out  1  data memory read strobe.
- mem_write  out  1  data memory write strobe.
- halted  out  1  controller in HALT.
- err  out  2  halt cause: 00 none, 01 illegal opcode, 10 memory timeout.
- instret  out  32  retired-instruction count; wraps 0xFFFFFFFF -> 0.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LS, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JALR, HALT.
- FETCH: ir_write=1, pc_write=1, pc_src=00. Next: DECODE.
- DECODE: all strobes 0. Next by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> EXEC_LS; 1100011 -> BRANCH; 1100111 -> JALR; any other -> HALT, err=01.
- EXEC_R: alu_src=0, alu_op=10 -> WB_ALU. EXEC_I: alu_src=1, alu_op=11 -> WB_ALU.
- EXEC_LS: alu_src=1, alu_op=00. Next: MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_read=1, alu_src=1, alu_op=00, held until mem_ready. mem_ready=1 -> WB_MEM. MEM_WR: same, with mem_write=1. mem_ready=1 -> FETCH (retire).
- WB_ALU: reg_write=1, wb_sel=00, ALU controls held from the EXEC state -> FETCH (retire). WB_MEM: reg_write=1, wb_sel=01 -> FETCH (retire).
- BRANCH (BEQ): alu_src=0, alu_op=01, pc_src=01, pc_write=zero -> FETCH (retire).
- JALR: alu_src=1, alu_op=00, reg_write=1, wb_sel=10, pc_write=1, pc_src=10 -> FETCH (retire).
- HALT: absorbing; all strobes 0, halted=1, err held. Left only by reset.
- Wait counter, 8 bits:
  - Cleared on entry to MEM_RD/MEM_WR; increments each cycle spent there with mem_ready=0.
  - When the counter reaches MEM_TIMEOUT with mem_ready=0 -> HALT, err=10.
  - mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT counts as success; no halt.
- instret increments by 1 on the clock edge leaving a retire cycle. It does not increment on entry to HALT.
- Outputs are pure decodes of the state, plus zero in BRANCH. Unlisted outputs are 0 in each state.

## Timing
- Reset assertion takes effect immediately (asynchronous). Release: the first rising edge after deassertion executes FETCH (outputs show FETCH during that cycle).
- Latency (FETCH through retire, inclusive): R/I 4 cycles; load 5 + w; store 4 + w; branch 3; jalr 3. w = number of cycles with mem_ready=0 before ready.
- mem_ready is ignored outside MEM_RD/MEM_WR. mem_read/mem_write stay stable and continuous until the handshake completes.
- Reset mid-instruction aborts it: no retire, no partial writes after the reset edge, instret cleared.

## Test plan
- ADD (opcode 0110011), mem_ready don't-care -> states FETCH,DECODE,EXEC_R,WB_ALU; reg_write=1 only in cycle 4; instret 0 -> 1.
- LW with mem_ready low 3 cycles then high -> mem_read=1 for 4 consecutive cycles; WB_MEM with wb_sel=01; total 8 cycles; instret +1.
- SW with mem_ready held low, MEM_TIMEOUT=4 -> HALT after 4 wait cycles; halted=1, err=10; mem_write drops to 0; instret unchanged.
- BEQ with zero=1, then with zero=0 -> pc_write=1/pc_src=01 vs pc_write=0; each instruction 3 cycles.
- Opcode 1111111 -> HALT from DECODE, err=01. Then pulse reset -> halted=0, err=00, instret=0, FETCH.
- Preload instret=0xFFFFFFFF by running 2^32 retires (or force), then one JALR -> instret=0; reg_write, pc_write=1, pc_src=10, wb_sel=10 in the same cycle.
